// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the accumulator ALU sequencer and its datapath:
//   - 3-bit opcode constants
//   - sequencer state encoding
//   - bit positions of the {N,Z,C,V} status flags
//   - small helpers for opcode classification and flag packing
// Optional feature macro used by the importing files: ALU_FLAGS_EN
// -----------------------------------------------------------------------------
package alu_pkg;

    // Opcodes carried on cmd_op
    localparam logic [2:0] OP_LOAD = 3'b000;  // result = B
    localparam logic [2:0] OP_ADD  = 3'b001;  // result = A + B
    localparam logic [2:0] OP_SUB  = 3'b010;  // result = A - B
    localparam logic [2:0] OP_AND  = 3'b011;  // result = A & B
    localparam logic [2:0] OP_OR   = 3'b100;  // result = A | B
    localparam logic [2:0] OP_XOR  = 3'b101;  // result = A ^ B
    localparam logic [2:0] OP_SHL  = 3'b110;  // result = A << 1
    localparam logic [2:0] OP_NOP  = 3'b111;  // no write-back, flags kept

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

    // Flag vector layout is {N,Z,C,V}
    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Every opcode except NOP writes the accumulator and updates the flags
    function automatic logic op_has_effect(input logic [2:0] op);
        return (op != OP_NOP);
    endfunction

    // Place individual flag bits at their architectural positions
    function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                     input logic c, input logic v);
        logic [FLAG_W-1:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational 8-bit ALU datapath used once by alu_acc_seq.
// All arithmetic wraps modulo 256.
// Ports:
//   op_i      [2:0]  opcode (alu_pkg OP_*)
//   a_i       [7:0]  operand A (sampled accumulator)
//   b_i       [7:0]  operand B (command operand)
//   result_o  [7:0]  8-bit result
//   n_o/z_o/c_o/v_o  raw status flags (only when ALU_FLAGS_EN is defined)
// Optional feature macro: ALU_FLAGS_EN
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] result_o
`ifdef ALU_FLAGS_EN
    ,
    output logic       n_o,
    output logic       z_o,
    output logic       c_o,
    output logic       v_o
`endif
);

    // Result selection; assignment to an 8-bit target truncates add/sub/shift
    always_comb begin
        result_o = a_i;
        case (op_i)
            OP_LOAD: result_o = b_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SHL:  result_o = {a_i[6:0], 1'b0};
            OP_NOP:  result_o = a_i;
            default: result_o = a_i;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic add_carry_s;
    logic sub_borrow_s;

    assign add_carry_s  = ((9'(a_i) + 9'(b_i)) > 9'd255);
    assign sub_borrow_s = (a_i < b_i);

    // Carry/overflow per opcode; overflow compares operand signs with the result sign
    always_comb begin
        c_o = 1'b0;
        v_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                c_o = add_carry_s;
                v_o = (a_i[7] == b_i[7]) && (result_o[7] != a_i[7]);
            end
            OP_SUB: begin
                c_o = sub_borrow_s;
                v_o = (a_i[7] != b_i[7]) && (result_o[7] != a_i[7]);
            end
            OP_SHL: begin
                c_o = a_i[7];
                v_o = 1'b0;
            end
            default: begin
                c_o = 1'b0;
                v_o = 1'b0;
            end
        endcase
    end

    assign n_o = result_o[7];
    assign z_o = (result_o == 8'd0);
`endif

endmodule

// File: rtl/alu_acc_seq.sv
// -----------------------------------------------------------------------------
// alu_acc_seq
// Four-state sequencer (IDLE -> READ -> EXEC -> WRITE) that accepts one ALU
// command, samples the external accumulator after READ_WAIT cycles, computes
// the result through alu_core and writes it back with a one-cycle strobe.
// Latency from accepting edge to WRITE cycle is READ_WAIT+2; a continuously
// offered stream is accepted every READ_WAIT+3 cycles.
// Parameters:
//   READ_WAIT   cycles spent in READ before acc_q is sampled (1..15)
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   cmd_valid    command offered
//   cmd_ready    command can be accepted (IDLE only)
//   cmd_op       [2:0] opcode
//   cmd_operand  [7:0] operand B
//   acc_q        [7:0] current accumulator value (operand A)
//   acc_d        [7:0] write-back value, holds last written result
//   acc_update   write strobe, one cycle in WRITE (never for NOP)
//   done         one-cycle completion pulse in WRITE (every opcode)
//   busy         high outside IDLE
//   flags        [3:0] {N,Z,C,V} (only when ALU_FLAGS_EN is defined)
// Optional feature macro: ALU_FLAGS_EN
// -----------------------------------------------------------------------------
module alu_acc_seq
    import alu_pkg::*;
#(
    parameter int READ_WAIT = 1
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_operand,
    input  logic [7:0] acc_q,
    output logic [7:0] acc_d,
    output logic       acc_update,
    output logic       done,
    output logic       busy
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0] flags
`endif
);

    // Counter value on the final READ cycle
    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [2:0] op_q,    op_d;
    logic [7:0] b_q,     b_d;
    logic [7:0] a_q,     a_d;
    logic [7:0] wb_q,    wb_d;
    logic       upd_q,   upd_d;
    logic       done_q,  done_d;
    logic       ready_q, ready_d;
    logic       busy_q,  busy_d;

    logic [7:0] alu_res_s;

`ifdef ALU_FLAGS_EN
    logic       alu_n_s;
    logic       alu_z_s;
    logic       alu_c_s;
    logic       alu_v_s;
    logic [3:0] flags_q, flags_d;
`endif

    alu_core u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_res_s)
`ifdef ALU_FLAGS_EN
        ,
        .n_o      (alu_n_s),
        .z_o      (alu_z_s),
        .c_o      (alu_c_s),
        .v_o      (alu_v_s)
`endif
    );

    // Next-state, command latching and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        a_d     = a_q;
        wb_d    = wb_q;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = ST_READ;
                    cnt_d   = 4'd0;
                    op_d    = cmd_op;
                    b_d     = cmd_operand;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // acc_q is captured on the last READ edge only
                if (cnt_q == WAIT_LAST) begin
                    a_d     = acc_q;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_EXEC: begin
                // Result is registered here so WRITE presents it straight from flops
                state_d = ST_WRITE;
                done_d  = 1'b1;
                if (op_has_effect(op_q)) begin
                    upd_d = 1'b1;
                    wb_d  = alu_res_s;
                end else begin
                    upd_d = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Sequencer registers; reset aborts any command in flight immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'b000;
            b_q     <= 8'd0;
            a_q     <= 8'd0;
            wb_q    <= 8'd0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            a_q     <= a_d;
            wb_q    <= wb_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ALU_FLAGS_EN
    // Flags follow the result registered in EXEC; NOP keeps the previous flags
    always_comb begin
        flags_d = flags_q;
        if ((state_q == ST_EXEC) && op_has_effect(op_q)) begin
            flags_d = pack_flags(alu_n_s, alu_z_s, alu_c_s, alu_v_s);
        end else begin
            flags_d = flags_q;
        end
    end

    // Flag register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`endif

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign acc_d      = wb_q;
    assign acc_update = upd_q;
    assign done       = done_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_acc_seq
// Self-checking bench for alu_acc_seq. A transaction-level reference model
// (accept edge, sample edge, write edge, plain integer arithmetic) predicts
// every output after every clock edge; directed scenarios add explicit checks
// with fixed expected values. Flag checks are compiled in with ALU_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_alu_acc_seq;
    import alu_pkg::*;

    localparam int RW = 1;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       cmd_valid   = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op      = 3'b000;
    logic [7:0] cmd_operand = 8'h00;
    logic [7:0] acc_q       = 8'h00;
    logic [7:0] acc_d;
    logic       acc_update;
    logic       done;
    logic       busy;
`ifdef ALU_FLAGS_EN
    logic [3:0] flags;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (edge numbers count rising edges after reset release)
    int e         = 0;
    int next_free = 0;   // first edge at which a new command can be accepted
    int samp_edge = -1;  // edge at which acc_q is taken as operand A
    int wr_edge   = -1;  // edge after which the WRITE cycle is visible
    int p_op = 0, p_a = 0, p_b = 0;
    int m_acc   = 0;
    int m_flags = 0;
    int acc_edges[$];

    alu_acc_seq #(.READ_WAIT(RW)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .acc_q       (acc_q),
        .acc_d       (acc_d),
        .acc_update  (acc_update),
        .done        (done),
        .busy        (busy)
`ifdef ALU_FLAGS_EN
        ,
        .flags       (flags)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic int ref_res(input int op, input int a, input int b);
        case (op)
            0:       return b;
            1:       return (a + b) % 256;
            2:       return (a - b + 256) % 256;
            3:       return a & b;
            4:       return a | b;
            5:       return a ^ b;
            6:       return (a * 2) % 256;
            default: return a;
        endcase
    endfunction

    function automatic int ref_flags(input int op, input int a, input int b, input int old);
        int r, sa, sb, n, z, c, v;
        if (op == 7) return old;
        r  = ref_res(op, a, b);
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        n  = (r >= 128) ? 1 : 0;
        z  = (r == 0) ? 1 : 0;
        c  = 0;
        v  = 0;
        if (op == 1) begin
            c = (a + b > 255) ? 1 : 0;
            v = ((sa + sb > 127) || (sa + sb < -128)) ? 1 : 0;
        end
        if (op == 2) begin
            c = (a < b) ? 1 : 0;
            v = ((sa - sb > 127) || (sa - sb < -128)) ? 1 : 0;
        end
        if (op == 6) c = (a >= 128) ? 1 : 0;
        return n * 8 + z * 4 + c * 2 + v;
    endfunction

    // One clock: drive inputs, let the model react to the edge, compare at negedge
    task automatic tick(input logic v, input logic [2:0] op, input logic [7:0] b, input logic [7:0] a);
        int r;
        logic x_done, x_upd, x_idle;
        cmd_valid   = v;
        cmd_op      = op;
        cmd_operand = b;
        acc_q       = a;
        if (v && cmd_ready) acc_edges.push_back(e);
        @(posedge clock);
        if (v && (e >= next_free)) begin
            p_op      = int'(op);
            p_b       = int'(b);
            samp_edge = e + RW;
            wr_edge   = e + RW + 1;
            next_free = e + RW + 3;
        end
        if (e == samp_edge) p_a = int'(a);
        x_done = (e == wr_edge);
        x_upd  = 1'b0;
        if (x_done) begin
            r = ref_res(p_op, p_a, p_b);
            if (p_op != 7) begin
                x_upd = 1'b1;
                m_acc = r;
            end
            m_flags = ref_flags(p_op, p_a, p_b, m_flags);
        end
        x_idle = ((e + 1) >= next_free);
        @(negedge clock);
        chk("done",       32'(done),       32'(x_done));
        chk("acc_update", 32'(acc_update), 32'(x_upd));
        chk("acc_d",      32'(acc_d),      32'(m_acc));
        chk("cmd_ready",  32'(cmd_ready),  32'(x_idle));
        chk("busy",       32'(busy),       32'(!x_idle));
`ifdef ALU_FLAGS_EN
        chk("flags",      32'(flags),      32'(m_flags));
`endif
        e++;
    endtask

    // Wait until idle, issue one command, stop on its WRITE cycle
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] b, input logic [7:0] a);
        repeat (RW + 3) tick(1'b0, OP_NOP, 8'h00, a);
        tick(1'b1, op, b, a);
        repeat (RW + 1) tick(1'b0, op, b, a);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock
    task automatic reset_mid();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_ready", 32'(cmd_ready),  32'd1);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_upd",   32'(acc_update), 32'd0);
        chk("rst_acc_d", 32'(acc_d),      32'd0);
`ifdef ALU_FLAGS_EN
        chk("rst_flags", 32'(flags),      32'd0);
`endif
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b0;
        next_free = e;
        samp_edge = -1;
        wr_edge   = -1;
        m_acc     = 0;
        m_flags   = 0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("init_busy",  32'(busy),       32'd0);
        chk("init_ready", 32'(cmd_ready),  32'd1);
        chk("init_done",  32'(done),       32'd0);
        chk("init_upd",   32'(acc_update), 32'd0);
        chk("init_acc_d", 32'(acc_d),      32'd0);
        reset = 1'b0;

        // ADD 0x10 + 0x05, write-back on the WRITE cycle, ready again one cycle later
        do_cmd(OP_ADD, 8'h05, 8'h10);
        chk("add_acc_d", 32'(acc_d),      32'h15);
        chk("add_upd",   32'(acc_update), 32'd1);
        chk("add_done",  32'(done),       32'd1);
        tick(1'b0, OP_NOP, 8'h00, 8'h10);
        chk("add_ready", 32'(cmd_ready),  32'd1);

        // Wrap to zero with carry
        do_cmd(OP_ADD, 8'h01, 8'hFF);
        chk("wrap_acc_d", 32'(acc_d), 32'h00);
`ifdef ALU_FLAGS_EN
        chk("wrap_flags", 32'(flags), 32'b0110);
`endif

        // Signed overflow on subtract
        do_cmd(OP_SUB, 8'h01, 8'h80);
        chk("sub_acc_d", 32'(acc_d), 32'h7F);
`ifdef ALU_FLAGS_EN
        chk("sub_flags", 32'(flags), 32'b0001);
`endif

        // Set flags to N,C then NOP must leave them and acc_d alone
        do_cmd(OP_ADD, 8'h81, 8'hFF);
        chk("nc_acc_d", 32'(acc_d), 32'h80);
        do_cmd(OP_NOP, 8'h55, 8'h12);
        chk("nop_done",  32'(done),       32'd1);
        chk("nop_upd",   32'(acc_update), 32'd0);
        chk("nop_acc_d", 32'(acc_d),      32'h80);
`ifdef ALU_FLAGS_EN
        chk("nop_flags", 32'(flags),      32'b1010);
`endif

        // Reset while in READ aborts the command
        repeat (RW + 3) tick(1'b0, OP_NOP, 8'h00, 8'h01);
        tick(1'b1, OP_ADD, 8'h22, 8'h01);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset_mid();
        repeat (RW + 4) tick(1'b0, OP_NOP, 8'h00, 8'h01);
        chk("post_rst_acc_d", 32'(acc_d), 32'd0);

        // cmd_valid held high; operands change while busy
        repeat (RW + 3) tick(1'b0, OP_NOP, 8'h00, 8'h33);
        acc_edges.delete();
        tick(1'b1, OP_LOAD, 8'h33, 8'h33);
        repeat (RW + 1) tick(1'b1, OP_XOR, 8'h0F, 8'h33);
        chk("hold_first", 32'(acc_d), 32'h33);
        repeat (2) tick(1'b1, OP_XOR, 8'h0F, 8'h33);
        repeat (RW + 1) tick(1'b0, OP_LOAD, 8'h99, 8'h33);
        chk("hold_second", 32'(acc_d), 32'h3C);
        chk("hold_n_acc", 32'(acc_edges.size()), 32'd2);
        if (acc_edges.size() >= 2) begin
            chk("hold_spacing", 32'(acc_edges[1] - acc_edges[0]), 32'(RW + 3));
        end

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 199) == 0) reset_mid();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_acc_seq.md
ALU_ACC_SEQ -- requirements
Module: alu_acc_seq

Interface
REQ-001 Parameter READ_WAIT, default 1, cycles spent in READ before acc_q is sampled; legal range 1..15.
REQ-002 clock  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  3  opcode; codes defined in the shared package.
REQ-007 cmd_operand  input  8  operand B.
REQ-008 acc_q  input  8  current accumulator value (operand A).
REQ-009 acc_d  output  8  write-back value to accumulator.
REQ-010 acc_update  output  1  write strobe to accumulator, one cycle.
REQ-011 done  output  1  one-cycle pulse: command completed.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 flags  output  4  {N,Z,C,V}; present only when ALU_FLAGS_EN is defined.

Function
REQ-014 States IDLE, READ, EXEC, WRITE; IDLE->READ on cmd_valid&&cmd_ready; READ->EXEC after READ_WAIT cycles; EXEC->WRITE; WRITE->IDLE unconditionally.
REQ-015 cmd_ready SHALL be 1 only in IDLE; op and operand latched on the accepting edge; cmd_valid outside IDLE ignored.
REQ-016 acc_q SHALL be sampled on the final READ edge; EXEC SHALL register the result.
REQ-017 Opcodes: 000 LOAD (B), 001 ADD (A+B), 010 SUB (A-B), 011 AND, 100 OR, 101 XOR, 110 SHL (A<<1, bit0=0), 111 NOP.
REQ-018 All arithmetic modulo 256; results truncated to 8 bits.
REQ-019 In WRITE, acc_update=1 and acc_d=result, except NOP: acc_update stays 0.
REQ-020 done SHALL pulse for exactly the WRITE cycle for every op including NOP.
REQ-021 acc_d SHALL hold the last written result outside WRITE.
REQ-022 Fixed latency: accept edge to WRITE cycle = READ_WAIT+2 cycles; back-to-back accepts every READ_WAIT+3 cycles.
REQ-023 cmd_valid held high continuously SHALL be accepted again on the first IDLE cycle after WRITE.

Reset
REQ-024 Reset SHALL force IDLE and clear latched command immediately, without waiting for clock.
REQ-025 Reset values: cmd_ready=1 after release, acc_update=0, done=0, busy=0, acc_d=0, flags=0.
REQ-026 Reset mid-command SHALL abort it with no acc_update and no done pulse.

Configuration
REQ-027 Macro ALU_FLAGS_EN: when defined, flags port and 4-bit flag register exist, updated in EXEC and held otherwise.
REQ-028 Flags: Z=(result==0), N=result[7]; ADD C=carry-out, V=signed overflow; SUB C=borrow (A<B unsigned), V=signed overflow; SHL C=A[7], V=0; LOAD/logic C=0, V=0; NOP leaves all flags unchanged.
REQ-029 When undefined: no flags port, no flag logic; all other behaviour identical.

Structure
REQ-030 Shared package alu_pkg SHALL hold the 3-bit opcode constants, state encoding, and flag bit indices.
REQ-031 Combinational datapath SHALL be sub-module alu_core (inputs op, A, B; outputs result and raw N,Z,C,V); sequencer instantiates it once.

Verification
REQ-032 Reset asserted mid-READ -> state IDLE at once, no acc_update, no done, acc_d=0.
REQ-033 READ_WAIT=1, acc_q=0x10, ADD B=0x05 accepted at edge 0 -> acc_update=1, acc_d=0x15, done=1 in cycle 3; cmd_ready=1 in cycle 4.
REQ-034 acc_q=0xFF, ADD B=0x01 -> acc_d=0x00; flags Z=1,C=1,V=0,N=0.
REQ-035 acc_q=0x80, SUB B=0x01 -> acc_d=0x7F; flags V=1,C=0,N=0,Z=0.
REQ-036 NOP with flags previously 0b1010 -> done pulses, acc_update stays 0, flags remain 0b1010.
REQ-037 cmd_valid held high with LOAD 0x33 then changed during busy -> only values present at accept edges used; accepts spaced exactly READ_WAIT+3 cycles.
